// File: rtl/parking_lane_monitor_pkg.sv
// parking_pkg: shared types and helpers for the parking lane monitor.
//   lane_state_t      - per-lane direction FSM state
//   S_*               - filtered sensor-pair encoding {outer, inner}
//   next_lane_state() - pure next-state function of the lane FSM
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    E1      = 3'd1,
    E2      = 3'd2,
    E3      = 3'd3,
    X1      = 3'd4,
    X2      = 3'd5,
    X3      = 3'd6,
    RECOVER = 3'd7
  } lane_state_t;

  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_OUTER = 2'b10;
  localparam logic [1:0] S_BOTH  = 2'b11;
  localparam logic [1:0] S_INNER = 2'b01;

  // Any pair not listed for a state holds that state; an illegal jump parks in RECOVER,
  // which only releases once both sensors read clear.
  function automatic lane_state_t next_lane_state(input lane_state_t st, input logic [1:0] p);
    lane_state_t nxt;
    nxt = st;
    case (st)
      IDLE: begin
        case (p)
          S_OUTER: nxt = E1;
          S_INNER: nxt = X1;
          S_BOTH:  nxt = RECOVER;
          default: nxt = IDLE;
        endcase
      end
      E1: begin
        case (p)
          S_BOTH:  nxt = E2;
          S_CLEAR: nxt = IDLE;
          S_INNER: nxt = RECOVER;
          default: nxt = E1;
        endcase
      end
      E2: begin
        case (p)
          S_INNER: nxt = E3;
          S_OUTER: nxt = E1;
          S_CLEAR: nxt = RECOVER;
          default: nxt = E2;
        endcase
      end
      E3: begin
        case (p)
          S_CLEAR: nxt = IDLE;
          S_BOTH:  nxt = E2;
          S_OUTER: nxt = RECOVER;
          default: nxt = E3;
        endcase
      end
      X1: begin
        case (p)
          S_BOTH:  nxt = X2;
          S_CLEAR: nxt = IDLE;
          S_OUTER: nxt = RECOVER;
          default: nxt = X1;
        endcase
      end
      X2: begin
        case (p)
          S_OUTER: nxt = X3;
          S_INNER: nxt = X1;
          S_CLEAR: nxt = RECOVER;
          default: nxt = X2;
        endcase
      end
      X3: begin
        case (p)
          S_CLEAR: nxt = IDLE;
          S_BOTH:  nxt = X2;
          S_INNER: nxt = RECOVER;
          default: nxt = X3;
        endcase
      end
      RECOVER: begin
        case (p)
          S_CLEAR: nxt = IDLE;
          default: nxt = RECOVER;
        endcase
      end
      default: nxt = RECOVER;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// parking_lane_fsm: one gate lane. Synchronises and debounces the outer/inner sensors,
// then tracks the car direction and emits one-cycle enter/exit pulses.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   outer, inner  - raw sensors, 1 = blocked
//   enter, exit   - registered one-cycle completion pulses
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic outer,
  input  logic inner,
  output logic enter,
  output logic exit
);

  localparam int DCW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'((DEBOUNCE == 0) ? 0 : DEBOUNCE - 1);

  logic [1:0]     meta_r;
  logic [1:0]     sync_r;
  logic [1:0]     filt_r;
  logic [DCW-1:0] cnt_r [2];
  lane_state_t    state_r;
  logic           enter_r;
  logic           exit_r;

  // Two-flop synchroniser for the {outer, inner} pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= {outer, inner};
      sync_r <= meta_r;
    end
  end

  // Per-sensor debounce: a new level is accepted on the DEBOUNCE-th consecutive
  // differing cycle; any agreeing cycle restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_r <= 2'b00;
      for (int b = 0; b < 2; b++) cnt_r[b] <= {DCW{1'b0}};
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (DEBOUNCE == 0) begin
          filt_r[b] <= sync_r[b];
          cnt_r[b]  <= {DCW{1'b0}};
        end else if (sync_r[b] != filt_r[b]) begin
          if (cnt_r[b] == DB_LAST) begin
            filt_r[b] <= sync_r[b];
            cnt_r[b]  <= {DCW{1'b0}};
          end else begin
            cnt_r[b] <= cnt_r[b] + DCW'(1);
          end
        end else begin
          cnt_r[b] <= {DCW{1'b0}};
        end
      end
    end
  end

  // Direction FSM and registered completion pulses; reset parks in RECOVER so a
  // sequence cut by reset can never be completed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RECOVER;
      enter_r <= 1'b0;
      exit_r  <= 1'b0;
    end else begin
      state_r <= next_lane_state(state_r, filt_r);
      enter_r <= (state_r == E3) && (filt_r == S_CLEAR);
      exit_r  <= (state_r == X3) && (filt_r == S_CLEAR);
    end
  end

  assign enter = enter_r;
  assign exit  = exit_r;

endmodule

// File: rtl/parking_lane_monitor.sv
// parking_lane_monitor: N_LANES independent gate lanes merged into a saturating
// lot-occupancy counter.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   outer, inner        - raw sensors per lane, 1 = blocked
//   enter, exit         - one-cycle completion pulses per lane
//   count               - registered occupancy 0..CAPACITY
//   full, empty         - decoded from registered count
//   overflow, underflow - one-cycle pulses when pulses were discarded by clamping
module parking_lane_monitor
  import parking_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int CAPACITY = 15,
  parameter int DEBOUNCE = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_LANES-1:0]              outer,
  input  logic [N_LANES-1:0]              inner,
  output logic [N_LANES-1:0]              enter,
  output logic [N_LANES-1:0]              exit,
  output logic [$clog2(CAPACITY+1)-1:0]   count,
  output logic                            full,
  output logic                            empty,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam int NW = CW + $clog2(N_LANES + 1) + 1;
  localparam logic signed [NW-1:0] CAP_S  = NW'(CAPACITY);
  localparam logic signed [NW-1:0] ZERO_S = {NW{1'b0}};

  logic [CW-1:0]          count_r;
  logic                   overflow_r;
  logic                   underflow_r;
  logic [NW-1:0]          pc_enter_s;
  logic [NW-1:0]          pc_exit_s;
  logic signed [NW-1:0]   net_s;
  logic signed [NW-1:0]   sum_s;
  logic [CW-1:0]          count_nxt_s;
  logic                   overflow_nxt_s;
  logic                   underflow_nxt_s;

  function automatic logic [NW-1:0] popcount(input logic [N_LANES-1:0] v);
    logic [NW-1:0] acc;
    acc = {NW{1'b0}};
    for (int k = 0; k < N_LANES; k++) acc = acc + NW'(v[k]);
    return acc;
  endfunction

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    parking_lane_fsm #(
      .DEBOUNCE(DEBOUNCE)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .outer(outer[g]),
      .inner(inner[g]),
      .enter(enter[g]),
      .exit (exit[g])
    );
  end

  // Net all lane pulses first, then clamp once, so opposite pulses cancel at the limits.
  always_comb begin
    pc_enter_s      = popcount(enter);
    pc_exit_s       = popcount(exit);
    net_s           = $signed(pc_enter_s) - $signed(pc_exit_s);
    sum_s           = $signed(NW'(count_r)) + net_s;
    count_nxt_s     = count_r;
    overflow_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;
    if (sum_s > CAP_S) begin
      count_nxt_s    = CW'(CAPACITY);
      overflow_nxt_s = 1'b1;
    end else if (sum_s < ZERO_S) begin
      count_nxt_s     = {CW{1'b0}};
      underflow_nxt_s = 1'b1;
    end else begin
      count_nxt_s = sum_s[CW-1:0];
    end
  end

  // Occupancy register and its error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign full      = (count_r == CW'(CAPACITY));
  assign empty     = (count_r == {CW{1'b0}});

endmodule

// File: tb/tb_parking_lane_monitor.sv
module tb_parking_lane_monitor;
  import parking_pkg::*;

  localparam int N_LANES  = 2;
  localparam int CAPACITY = 3;
  localparam int DEBOUNCE = 4;
  localparam int CW       = $clog2(CAPACITY + 1);
  localparam int HOLD     = 10;

  logic                clk;
  logic                reset;
  logic [N_LANES-1:0]  outer;
  logic [N_LANES-1:0]  inner;
  logic [N_LANES-1:0]  enter;
  logic [N_LANES-1:0]  exit;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                overflow;
  logic                underflow;

  typedef struct {
    logic [1:0]    en;
    logic [1:0]    ex;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   pending;
  int   checks = 0;
  int   errors = 0;

  parking_lane_monitor #(
    .N_LANES (N_LANES),
    .CAPACITY(CAPACITY),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .outer    (outer),
    .inner    (inner),
    .enter    (enter),
    .exit     (exit),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [1:0] p);
    outer[lane] = p[1];
    inner[lane] = p[0];
  endtask

  task automatic push(input logic [1:0] en, input logic [1:0] ex, input logic [CW-1:0] cnt,
                      input logic ovf, input logic unf);
    exp_t e;
    e.en = en; e.ex = ex; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
    q.push_back(e);
  endtask

  // Drive a four-step sequence on one lane; the expectation is queued before the final step.
  task automatic seq1(input int lane, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input bit pulse, input exp_t e);
    set_lane(lane, a); hold(HOLD);
    set_lane(lane, b); hold(HOLD);
    set_lane(lane, c); hold(HOLD);
    if (pulse) q.push_back(e);
    set_lane(lane, 2'b00); hold(HOLD);
  endtask

  // Same sequence steps on both lanes at once.
  task automatic seq2(input logic [1:0] a0, input logic [1:0] b0, input logic [1:0] c0,
                      input logic [1:0] a1, input logic [1:0] b1, input logic [1:0] c1,
                      input exp_t e);
    set_lane(0, a0); set_lane(1, a1); hold(HOLD);
    set_lane(0, b0); set_lane(1, b1); hold(HOLD);
    set_lane(0, c0); set_lane(1, c1); hold(HOLD);
    q.push_back(e);
    set_lane(0, 2'b00); set_lane(1, 2'b00); hold(HOLD);
  endtask

  function automatic exp_t mk(input logic [1:0] en, input logic [1:0] ex, input logic [CW-1:0] cnt,
                              input logic ovf, input logic unf);
    exp_t e;
    e.en = en; e.ex = ex; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
    return e;
  endfunction

  // Monitor: pops one expectation per pulse, then checks counter outputs one cycle later.
  initial begin
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          check("count_after", 32'(count), 32'(cur.cnt));
          check("overflow", 32'(overflow), 32'(cur.ovf));
          check("underflow", 32'(underflow), 32'(cur.unf));
          check("full", 32'(full), 32'(cur.cnt == CW'(CAPACITY)));
          check("empty", 32'(empty), 32'(cur.cnt == '0));
          pending = 1'b0;
        end else if (overflow || underflow) begin
          checks++; errors++;
          $display("FAIL unexpected_flag: ovf=%0b unf=%0b expected 0 at %0t", overflow, underflow, $time);
        end
        if (enter != '0 || exit != '0) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: enter=%b exit=%b expected none at %0t", enter, exit, $time);
          end else begin
            cur = q.pop_front();
            check("enter", 32'(enter), 32'(cur.en));
            check("exit", 32'(exit), 32'(cur.ex));
            pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    outer = '0;
    inner = '0;
    hold(4);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_pulses", 32'({enter, exit, overflow, underflow}), 32'd0);
    check("rst_state", 32'(dut.g_lane[0].u_lane.state_r), 32'(RECOVER));
    reset = 1'b0;
    hold(HOLD);

    // 1: entry on lane 0
    seq1(0, 2'b10, 2'b11, 2'b01, 1'b1, mk(2'b01, 2'b00, 2'd1, 1'b0, 1'b0));
    check("t1_count", 32'(count), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);

    // 2: exit on lane 1
    seq1(1, 2'b01, 2'b11, 2'b10, 1'b1, mk(2'b00, 2'b10, 2'd0, 1'b0, 1'b0));
    check("t2_empty", 32'(empty), 32'd1);

    // 3: back out, then a 3-cycle glitch shorter than the debounce window
    seq1(0, 2'b10, 2'b11, 2'b10, 1'b0, mk(2'b00, 2'b00, 2'd0, 1'b0, 1'b0));
    set_lane(0, 2'b11); hold(3);
    set_lane(0, 2'b00); hold(12);
    check("t3_state", 32'(dut.g_lane[0].u_lane.state_r), 32'(IDLE));
    check("t3_count", 32'(count), 32'd0);

    // 4: fill to capacity, cancel at full, then overflow
    seq2(2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, mk(2'b11, 2'b00, 2'd2, 1'b0, 1'b0));
    seq1(0, 2'b10, 2'b11, 2'b01, 1'b1, mk(2'b01, 2'b00, 2'd3, 1'b0, 1'b0));
    check("t4_full", 32'(full), 32'd1);
    seq2(2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10, mk(2'b01, 2'b10, 2'd3, 1'b0, 1'b0));
    seq2(2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, mk(2'b11, 2'b00, 2'd3, 1'b1, 1'b0));
    check("t4_count", 32'(count), 32'd3);

    // 5: drain, then underflow at zero
    seq2(2'b01, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10, mk(2'b00, 2'b11, 2'd1, 1'b0, 1'b0));
    seq1(1, 2'b01, 2'b11, 2'b10, 1'b1, mk(2'b00, 2'b10, 2'd0, 1'b0, 1'b0));
    seq1(1, 2'b01, 2'b11, 2'b10, 1'b1, mk(2'b00, 2'b10, 2'd0, 1'b0, 1'b1));
    check("t5_empty", 32'(empty), 32'd1);

    // 6: reset with lane 0 in E2
    seq1(0, 2'b10, 2'b11, 2'b01, 1'b1, mk(2'b01, 2'b00, 2'd1, 1'b0, 1'b0));
    set_lane(0, 2'b10); hold(HOLD);
    set_lane(0, 2'b11); hold(HOLD);
    check("t6_in_e2", 32'(dut.g_lane[0].u_lane.state_r), 32'(E2));
    reset = 1'b1;
    hold(3);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_pulses", 32'({enter, exit, overflow, underflow}), 32'd0);
    reset = 1'b0;
    hold(12);
    check("t6_recover", 32'(dut.g_lane[0].u_lane.state_r), 32'(RECOVER));
    set_lane(0, 2'b01); hold(HOLD);
    set_lane(0, 2'b00); hold(HOLD);
    check("t6_idle", 32'(dut.g_lane[0].u_lane.state_r), 32'(IDLE));
    check("t6_count", 32'(count), 32'd0);
    seq1(0, 2'b10, 2'b11, 2'b01, 1'b1, mk(2'b01, 2'b00, 2'd1, 1'b0, 1'b0));

    hold(20);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
